// File: rtl/char_move.sv
// char_move: horizontal movement controller for the player sprite.
// Key levels are sampled once per video frame; border crashes seen during the
// frame (or in the frame-pulse cycle itself) block motion toward that border
// for that frame's decision. A bubble hit freezes the character until reset.
module char_move #(
  parameter int INIT_X = 304,
  parameter int Y_POS  = 400,
  parameter int SPEED  = 4,
  parameter int X_MAX  = 607
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        leftKey,
  input  logic        rightKey,
  input  logic        charCrashLeft,
  input  logic        charCrashRight,
  input  logic        hitByBubble,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  charState
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10,
    FROZEN = 2'b11
  } state_t;

  localparam logic [11:0] SPD   = 12'(SPEED);
  localparam logic [11:0] XMAX  = 12'(X_MAX);
  localparam logic [10:0] XINIT = 11'(INIT_X);

  state_t      state;
  logic        block_l, block_r;
  logic        eff_l, eff_r;
  logic [11:0] diff_l, sum_r;

  // A crash in the decision cycle itself still blocks that decision.
  assign eff_l  = block_l | charCrashLeft;
  assign eff_r  = block_r | charCrashRight;

  // 12-bit arithmetic: bit 11 of the difference flags underflow below 0.
  assign diff_l = {1'b0, topLeftX} - SPD;
  assign sum_r  = {1'b0, topLeftX} + SPD;

  assign topLeftY  = 11'(Y_POS);
  assign charState = state;

  // Sticky crash flags, per-frame movement decision, and freeze on hit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      topLeftX <= XINIT;
      block_l  <= 1'b0;
      block_r  <= 1'b0;
    end else begin
      // Flags accumulate between frame pulses and are consumed by the decision;
      // a crash coincident with the pulse is used once and not carried.
      if (startOfFrame) begin
        block_l <= 1'b0;
        block_r <= 1'b0;
      end else begin
        block_l <= block_l | charCrashLeft;
        block_r <= block_r | charCrashRight;
      end

      if (hitByBubble) begin
        // Freeze wins over any coincident move; X holds.
        state <= FROZEN;
      end else if (startOfFrame && state != FROZEN) begin
        if (leftKey && !rightKey && !eff_l) begin
          state    <= LEFT;
          topLeftX <= diff_l[11] ? 11'd0 : diff_l[10:0];
        end else if (rightKey && !leftKey && !eff_r) begin
          state    <= RIGHT;
          topLeftX <= (sum_r > XMAX) ? XMAX[10:0] : sum_r[10:0];
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_char_move.sv
// Bench for char_move: directed scenarios plus randomized traffic, every cycle
// compared against an integer-level behavioural model of the character.
module tb_char_move;

  localparam int INIT_X = 304;
  localparam int Y_POS  = 400;
  localparam int SPEED  = 4;
  localparam int X_MAX  = 607;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame, leftKey, rightKey;
  logic        charCrashLeft, charCrashRight, hitByBubble;
  logic [10:0] topLeftX, topLeftY;
  logic [1:0]  charState;

  char_move #(.INIT_X(INIT_X), .Y_POS(Y_POS), .SPEED(SPEED), .X_MAX(X_MAX)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .leftKey(leftKey), .rightKey(rightKey),
    .charCrashLeft(charCrashLeft), .charCrashRight(charCrashRight),
    .hitByBubble(hitByBubble),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .charState(charState)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: character position, mode (0 idle,1 left,2 right,3 frozen)
  // and whether each border was touched since the last frame pulse.
  int  m_x, m_st;
  bit  m_hit_l, m_hit_r;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = INIT_X; m_st = 0; m_hit_l = 0; m_hit_r = 0;
  endtask

  task automatic model_step(input bit sof, lk, rk, cl, cr, hit);
    bit bl, br;
    bl = m_hit_l || cl;
    br = m_hit_r || cr;
    if (hit) m_st = 3;
    else if (sof && m_st != 3) begin
      if (lk && !rk && !bl) begin
        m_st = 1;
        m_x  = (m_x - SPEED < 0) ? 0 : m_x - SPEED;
      end else if (rk && !lk && !br) begin
        m_st = 2;
        m_x  = (m_x + SPEED > X_MAX) ? X_MAX : m_x + SPEED;
      end else m_st = 0;
    end
    if (sof) begin m_hit_l = 0; m_hit_r = 0; end
    else begin m_hit_l = m_hit_l || cl; m_hit_r = m_hit_r || cr; end
  endtask

  // One clock: drive, advance model, check outputs 1 time unit after the edge.
  task automatic cyc(input bit sof, lk, rk, cl, cr, hit);
    startOfFrame = sof; leftKey = lk; rightKey = rk;
    charCrashLeft = cl; charCrashRight = cr; hitByBubble = hit;
    model_step(sof, lk, rk, cl, cr, hit);
    @(posedge clk); #1;
    chk("x", int'(topLeftX), m_x);
    chk("state", int'(charState), m_st);
    chk("y", int'(topLeftY), Y_POS);
  endtask

  // A short frame: three quiet cycles then the frame pulse.
  task automatic frame(input bit lk, rk);
    for (int i = 0; i < 3; i++) cyc(0, lk, rk, 0, 0, 0);
    cyc(1, lk, rk, 0, 0, 0);
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 0; leftKey = 0; rightKey = 0;
    charCrashLeft = 0; charCrashRight = 0; hitByBubble = 0;
    model_reset();
    #12;
    chk("rst_x", int'(topLeftX), INIT_X);
    chk("rst_state", int'(charState), 0);
    chk("rst_y", int'(topLeftY), Y_POS);
    @(posedge clk); #1;
    resetN = 1'b1;

    // Move right for three frames.
    frame(0, 1); frame(0, 1); frame(0, 1);
    chk("right3_x", int'(topLeftX), 316);
    chk("right3_state", int'(charState), 2);

    // Left crash mid-frame blocks the next decision only.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("crashL_idle_x", int'(topLeftX), 316);
    chk("crashL_idle_state", int'(charState), 0);
    frame(1, 0);
    chk("crashL_next_x", int'(topLeftX), 312);
    chk("crashL_next_state", int'(charState), 1);

    // Right crash coincident with the frame pulse.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 0);
    chk("coinc_state", int'(charState), 0);
    frame(0, 1);
    chk("coinc_next_state", int'(charState), 2);
    chk("coinc_next_x", int'(topLeftX), 316);

    // Both keys held.
    frame(1, 1);
    chk("both_x", int'(topLeftX), 316);
    chk("both_state", int'(charState), 0);

    // Run to the right edge and saturate at X_MAX, then left to 0.
    for (int i = 0; i < 75; i++) frame(0, 1);
    chk("sat_r_x", int'(topLeftX), X_MAX);
    for (int i = 0; i < 155; i++) frame(1, 0);
    chk("sat_l_x", int'(topLeftX), 0);

    // Randomized traffic, no hits.
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 0);

    // Asynchronous reset mid-move, observed without a clock edge.
    frame(0, 1); frame(0, 1);
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    chk("async_x", int'(topLeftX), INIT_X);
    chk("async_state", int'(charState), 0);
    chk("async_y", int'(topLeftY), Y_POS);
    @(posedge clk); #3;
    resetN = 1'b1;
    #1;

    // Crash seen after reset release still blocks the first decision.
    cyc(0, 0, 1, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("post_rst_block", int'(charState), 0);

    // Freeze coincident with a left move: X holds and stays frozen.
    frame(1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1);
    chk("freeze_state", int'(charState), 3);
    chk("freeze_x", int'(topLeftX), INIT_X - SPEED);
    for (int i = 0; i < 5; i++) frame(i[0], !i[0]);
    chk("frozen5_state", int'(charState), 3);
    chk("frozen5_x", int'(topLeftX), INIT_X - SPEED);
    for (int i = 0; i < 100; i++)
      cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1), 0);

    // Reset leaves FROZEN.
    resetN = 1'b0;
    #1;
    model_reset();
    chk("unfreeze_state", int'(charState), 0);
    chk("unfreeze_x", int'(topLeftX), INIT_X);
    @(posedge clk); #1;
    resetN = 1'b1;

    // Random traffic including rare hits.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 199) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
